sram_rd_arbiter: RTL and testbench

Round-robin read-port controller that shares the single read port of the 256-bit dual-port SRAM between two burst requesters: requester 0 is the AXI-to-SRAM bridge, requester 1 is a debug/DMA reader. It accepts one burst request at a time, sequences incrementing read addresses onto the SRAM read port, and routes the registered read data back to the granted requester with a last-beat marker. It sits between the requesters and the SRAM read port. It snoops the SRAM write port for optional read-after-write hazard stalls.

---
 rtl/sram_rd_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_rd_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rd_arbiter.sv
// Round-robin burst read controller sharing one SRAM read port between two requesters.
// Optional read-after-write stall on the snooped write port: define SRAM_RD_ARB_RAW_STALL_EN.
module sram_rd_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req_valid,
  output logic                  r0_req_ready,
  input  logic [ADDR_WIDTH-1:0] r0_req_addr,
  input  logic [LEN_WIDTH-1:0]  r0_req_len,
  output logic                  r0_rsp_valid,
  output logic [DATA_WIDTH-1:0] r0_rsp_data,
  output logic                  r0_rsp_last,
  input  logic                  r1_req_valid,
  output logic                  r1_req_ready,
  input  logic [ADDR_WIDTH-1:0] r1_req_addr,
  input  logic [LEN_WIDTH-1:0]  r1_req_len,
  output logic                  r1_rsp_valid,
  output logic [DATA_WIDTH-1:0] r1_rsp_data,
  output logic                  r1_rsp_last,
  output logic                  sram_ren,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic                  snoop_wen,
  input  logic [ADDR_WIDTH-1:0] snoop_waddr,
  output logic                  busy
);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic vld;
    logic id;
    logic last;
  } tag_t;

  state_t                state, state_nx;
  logic                  last_grant;
  logic                  gnt_id;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  beats_left;
  logic [ADDR_WIDTH-1:0] raddr_q;
  tag_t                  tag;
  logic                  win, acc, stall, issue;

`ifdef SRAM_RD_ARB_RAW_STALL_EN
  assign stall = snoop_wen && (snoop_waddr == cur_addr);
`else
  // SRAM is read-before-write, so a colliding read simply returns old data.
  logic unused_snoop;
  assign unused_snoop = ^{snoop_wen, snoop_waddr};
  assign stall = 1'b0;
`endif

  assign issue = (state == BURST) && !stall;

  always_comb begin
    state_nx     = state;
    win          = 1'b0;
    acc          = 1'b0;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    case (state)
      IDLE: begin
        // On contention the requester that did not win last time goes next.
        win          = (r0_req_valid && r1_req_valid) ? ~last_grant : r1_req_valid;
        acc          = r0_req_valid | r1_req_valid;
        r0_req_ready = acc && !win;
        r1_req_ready = acc && win;
        if (acc) state_nx = BURST;
      end
      BURST: if (issue && beats_left == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      cur_addr   <= '0;
      beats_left <= '0;
      raddr_q    <= '0;
      tag        <= '0;
    end else begin
      tag <= '{vld: issue, id: gnt_id, last: (beats_left == '0)};
      if (state == IDLE && acc) begin
        gnt_id     <= win;
        last_grant <= win;
        cur_addr   <= win ? r1_req_addr : r0_req_addr;
        beats_left <= win ? r1_req_len  : r0_req_len;
      end
      if (issue) begin
        cur_addr <= cur_addr + ADDR_WIDTH'(1);
        raddr_q  <= cur_addr;
        if (beats_left != '0) beats_left <= beats_left - LEN_WIDTH'(1);
      end
    end
  end

  // Address output holds the last issued address between issues.
  assign sram_ren   = issue;
  assign sram_raddr = issue ? cur_addr : raddr_q;

  assign r0_rsp_valid = tag.vld && !tag.id;
  assign r1_rsp_valid = tag.vld &&  tag.id;
  assign r0_rsp_last  = r0_rsp_valid && tag.last;
  assign r1_rsp_last  = r1_rsp_valid && tag.last;
  assign r0_rsp_data  = sram_rdata;
  assign r1_rsp_data  = sram_rdata;

  assign busy = (state == BURST) || tag.vld;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Randomized self-checking bench for sram_rd_arbiter with a behavioural SRAM and burst model.
module tb_sram_rd_arbiter;
  localparam int DW = 256;
  localparam int AW = 10;
  localparam int LW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          r0_req_valid = 1'b0, r1_req_valid = 1'b0;
  logic          r0_req_ready, r1_req_ready;
  logic [AW-1:0] r0_req_addr = '0, r1_req_addr = '0;
  logic [LW-1:0] r0_req_len = '0, r1_req_len = '0;
  logic          r0_rsp_valid, r1_rsp_valid, r0_rsp_last, r1_rsp_last;
  logic [DW-1:0] r0_rsp_data, r1_rsp_data;
  logic          sram_ren;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata = '0;
  logic          snoop_wen = 1'b0;
  logic [AW-1:0] snoop_waddr = '0;
  logic [DW-1:0] snoop_wdata = '0;
  logic          busy;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_init_done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_req_addr(r0_req_addr),
    .r0_req_len(r0_req_len), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
    .r0_rsp_last(r0_rsp_last),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_req_addr(r1_req_addr),
    .r1_req_len(r1_req_len), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
    .r1_rsp_last(r1_rsp_last),
    .sram_ren(sram_ren), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
    .snoop_wen(snoop_wen), .snoop_waddr(snoop_waddr), .busy(busy)
  );

  // SRAM: registered read, read-before-write on address collision.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      mem_init_done <= 1'b1;
    end else begin
      if (sram_ren) sram_rdata <= mem[sram_raddr];
      if (snoop_wen) mem[snoop_waddr] <= snoop_wdata;
    end
  end

  function automatic logic rdy(input logic id);
    return id ? r1_req_ready : r0_req_ready;
  endfunction
  function automatic logic rvld(input logic id);
    return id ? r1_rsp_valid : r0_rsp_valid;
  endfunction
  function automatic logic rlast(input logic id);
    return id ? r1_rsp_last : r0_rsp_last;
  endfunction
  function automatic logic [DW-1:0] rdat(input logic id);
    return id ? r1_rsp_data : r0_rsp_data;
  endfunction

  task automatic set_req(input logic id, input logic v, input int addr, input int len);
    if (id) begin r1_req_valid = v; r1_req_addr = AW'(addr); r1_req_len = LW'(len); end
    else    begin r0_req_valid = v; r0_req_addr = AW'(addr); r0_req_len = LW'(len); end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge after the burst.
  task automatic expect_burst(input logic id, input int addr, input int len);
    int n;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    n = len + 1;
    set_req(id, 1'b1, addr, len);
    #1;
    n_tests++;
    if (rdy(id) !== 1'b1) begin n_fail++; $display("FAIL accept_ready id=%0d got=%b want=1", id, rdy(id)); end
    n_tests++;
    if (rdy(!id) !== 1'b0) begin n_fail++; $display("FAIL loser_ready id=%0d got=%b want=0", !id, rdy(!id)); end
    @(posedge clk);
    @(negedge clk);
    set_req(id, 1'b0, addr, len);
    for (int k = 1; k <= n + 1; k++) begin
      #1;
      n_tests++;
      if (sram_ren !== (k <= n)) begin
        n_fail++; $display("FAIL ren id=%0d beat=%0d got=%b want=%b", id, k, sram_ren, (k <= n));
      end
      if (k <= n) begin
        ea = AW'((addr + k - 1) % DEPTH);
        n_tests++;
        if (sram_raddr !== ea) begin
          n_fail++; $display("FAIL raddr id=%0d beat=%0d got=%0d want=%0d", id, k, sram_raddr, ea);
        end
        n_tests++;
        if ({r0_req_ready, r1_req_ready} !== 2'b00) begin
          n_fail++; $display("FAIL ready_in_burst beat=%0d got=%b want=00", k, {r0_req_ready, r1_req_ready});
        end
      end
      n_tests++;
      if (rvld(id) !== (k >= 2) || rvld(!id) !== 1'b0) begin
        n_fail++; $display("FAIL rsp_valid id=%0d beat=%0d got=%b/%b want=%b/0", id, k, rvld(id), rvld(!id), (k >= 2));
      end
      if (k >= 2) begin
        ed = mem[(addr + k - 2) % DEPTH];
        n_tests++;
        if (rdat(id) !== ed) begin
          n_fail++; $display("FAIL rsp_data id=%0d beat=%0d got=%h want=%h", id, k, rdat(id), ed);
        end
        n_tests++;
        if (rlast(id) !== (k == n + 1)) begin
          n_fail++; $display("FAIL rsp_last id=%0d beat=%0d got=%b want=%b", id, k, rlast(id), (k == n + 1));
        end
      end
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy id=%0d beat=%0d got=%b want=1", id, k, busy); end
      if (k < n + 1) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_tests++;
    if ({r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_last, r1_rsp_last,
         sram_ren, busy} !== 8'h00 || sram_raddr !== '0) begin
      n_fail++;
      $display("FAIL %s got rdy=%b%b vld=%b%b last=%b%b ren=%b busy=%b raddr=%0d want all 0", tag,
               r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid, r0_rsp_last, r1_rsp_last,
               sram_ren, busy, sram_raddr);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1 check_reset_outputs("reset_state");
    apply_reset();
    #1 check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_single();
    expect_burst(1'b0, 5, 3);
  endtask

  task automatic test_round_robin();
    int a0, a1, l0, l1;
    apply_reset();
    a0 = $urandom_range(0, DEPTH - 1); l0 = $urandom_range(0, 15);
    a1 = $urandom_range(0, DEPTH - 1); l1 = $urandom_range(0, 15);
    set_req(1'b1, 1'b1, a1, l1);
    expect_burst(1'b0, a0, l0);
    expect_burst(1'b1, a1, l1);
    a1 = $urandom_range(0, DEPTH - 1);
    set_req(1'b1, 1'b1, a1, l1);
    expect_burst(1'b0, a0, l0);
    expect_burst(1'b1, a1, l1);
  endtask

  task automatic test_wrap();
    expect_burst(1'b1, 1022, 3);
  endtask

  task automatic test_random_bursts();
    for (int i = 0; i < 8; i++)
      expect_burst(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
  endtask

  task automatic test_raw();
    int s;
    logic [DW-1:0] old_d, new_d, d11, ed;
    logic exp_ren, exp_v, exp_last;
    logic [AW-1:0] exp_a;
`ifdef SRAM_RD_ARB_RAW_STALL_EN
    s = 1;
`else
    s = 0;
`endif
    old_d = mem[10];
    d11   = mem[11];
    new_d = ~old_d;
    set_req(1'b0, 1'b1, 10, 1);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 0, 0);
    snoop_wen = 1'b1; snoop_waddr = AW'(10); snoop_wdata = new_d;
    for (int k = 1; k <= 3 + s; k++) begin
      #1;
      exp_ren = (k == 1 + s) || (k == 2 + s);
      exp_a   = (k == 1 + s) ? AW'(10) : AW'(11);
      exp_v   = (k == 2 + s) || (k == 3 + s);
      exp_last = (k == 3 + s);
      ed = (k == 2 + s) ? ((s == 1) ? new_d : old_d) : d11;
      n_tests++;
      if (sram_ren !== exp_ren || (exp_ren && sram_raddr !== exp_a)) begin
        n_fail++; $display("FAIL raw_issue cyc=%0d got ren=%b addr=%0d want ren=%b addr=%0d", k, sram_ren, sram_raddr, exp_ren, exp_a);
      end
      n_tests++;
      if (r0_rsp_valid !== exp_v || r1_rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL raw_valid cyc=%0d got=%b want=%b", k, r0_rsp_valid, exp_v);
      end
      if (exp_v) begin
        n_tests++;
        if (r0_rsp_data !== ed || r0_rsp_last !== exp_last) begin
          n_fail++; $display("FAIL raw_data cyc=%0d got=%h/%b want=%h/%b", k, r0_rsp_data, r0_rsp_last, ed, exp_last);
        end
      end
      @(negedge clk);
      snoop_wen = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int a;
    a = $urandom_range(0, DEPTH - 1);
    set_req(1'b0, 1'b1, a, 7);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    n_tests++;
    if (sram_ren !== 1'b1 || sram_raddr !== AW'((a + 1) % DEPTH)) begin
      n_fail++; $display("FAIL mid_beat2 got ren=%b addr=%0d want ren=1 addr=%0d", sram_ren, sram_raddr, (a + 1) % DEPTH);
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset_now");
    repeat (3) begin
      @(negedge clk);
      #1 check_reset_outputs("mid_reset_hold");
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_reset_outputs("mid_reset_release");
    expect_burst(1'b1, $urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_random_bursts();
    test_raw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
